// File: rtl/blink_ctrl_pkg.sv
// Shared types and default widths for the blink_ctrl counter block.
// Optional prescaler is enabled with the BLINK_CTRL_PRESCALE_EN macro.
package blink_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int DEF_CNT_W = 8;
   localparam int DEF_PRE_W = 4;

endpackage

// File: rtl/blink_prescaler.sv
// Count-enable divider: while en is high, tick fires once every div+1 cycles.
// Used by blink_ctrl only when BLINK_CTRL_PRESCALE_EN is defined.
module blink_prescaler
   import blink_ctrl_pkg::*;
#(
   parameter int PRE_W = DEF_PRE_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [PRE_W-1:0] div,
   output logic             tick
);

   logic [PRE_W-1:0] pcnt;

   // >= rather than == so a div lowered mid-run still produces a tick promptly
   assign tick = en && (pcnt >= div);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         pcnt <= '0;
      end else if (en) begin
         pcnt <= tick ? '0 : pcnt + PRE_W'(1);
      end
   end

endmodule

// File: rtl/blink_ctrl.sv
// Start/stop/pause count controller with terminal-count done pulse and oe.
// Define BLINK_CTRL_PRESCALE_EN to insert the blink_prescaler tick divider.
module blink_ctrl
   import blink_ctrl_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int PRE_W = DEF_PRE_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             oneshot,
   input  logic [CNT_W-1:0] term,
   input  logic [PRE_W-1:0] pre_div,
   output logic [CNT_W-1:0] cnt,
   output logic             tick,
   output logic             busy,
   output logic             done,
   output logic             oe,
   output logic [1:0]       state_dbg
);

   state_e           state, state_n;
   logic [CNT_W-1:0] cnt_n;
   logic             done_n;
   logic             pre_clr;
   logic             run_st;

   assign run_st = (state == RUN);

`ifdef BLINK_CTRL_PRESCALE_EN
   blink_prescaler #(
      .PRE_W (PRE_W)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (pre_clr),
      .en   (run_st),
      .div  (pre_div),
      .tick (tick)
   );
`else
   logic unused_pre;
   assign unused_pre = ^{pre_div, pre_clr};
   assign tick       = run_st;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         done  <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      done_n  = 1'b0;
      pre_clr = 1'b0;
      if (stop) begin
         state_n = IDLE;
         cnt_n   = '0;
         pre_clr = 1'b1;
      end else if (start) begin
         state_n = RUN;
         cnt_n   = '0;
         pre_clr = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (tick) begin
                  if (cnt == term) begin
                     done_n = 1'b1;
                     if (oneshot) state_n = DONE;
                     else         cnt_n   = '0;
                  end else begin
                     // all-ones rolls over to zero with no done pulse
                     cnt_n = cnt + CNT_W'(1);
                  end
               end
               // a finishing one-shot run takes precedence over pause
               if (state_n == RUN && pause) state_n = HOLD;
            end
            HOLD: begin
               if (!pause) state_n = RUN;
            end
            DONE: begin
               state_n = IDLE;
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   assign busy      = (state == RUN) || (state == HOLD);
   assign oe        = busy && (cnt != '1);
   assign state_dbg = state;

endmodule

// File: doc/blink_ctrl.md
BLINK_CTRL -- requirements
Module: blink_ctrl

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, giving the count width.
REQ-002 The module SHALL have parameter PRE_W, default 4, giving the prescaler divide-select width.
REQ-003 The module SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset; synchronous, active-high
- start  input  1  begin or restart a count run
- stop  input  1  abort to IDLE
- pause  input  1  level; freeze count while high
- oneshot  input  1  1 = stop at terminal count; 0 = free-run with wrap
- term  input  CNT_W  terminal count value
- pre_div  input  PRE_W  prescale: one tick per pre_div+1 clk cycles
- cnt  output  CNT_W  current count (registered)
- tick  output  1  count-enable strobe
- busy  output  1  high in RUN or HOLD
- done  output  1  one-cycle pulse at terminal count
- oe  output  1  output enable

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, RUN, HOLD, DONE.
REQ-005 Input priority SHALL be stop > start > pause in every state.
REQ-006 In any state, stop=1 SHALL go to IDLE next cycle with cnt=0 and the prescaler cleared.
REQ-007 IDLE with start=1 SHALL go to RUN next cycle with cnt=0 and the prescaler cleared.
REQ-008 In RUN, start=1 SHALL restart: cnt=0 and the prescaler cleared next cycle, staying in RUN.
REQ-009 In RUN, cnt SHALL increment by 1 on each cycle where tick=1; cnt is latency-1 registered.
REQ-010 The terminal event SHALL be: RUN, tick=1, and cnt==term, sampled in the same cycle.
REQ-011 On the terminal event with oneshot=1, the FSM SHALL enter DONE, hold cnt=term, and pulse done for that one cycle.
REQ-012 On the terminal event with oneshot=0, cnt SHALL wrap to 0, the FSM SHALL stay in RUN, and done SHALL pulse one cycle.
REQ-013 With term=0 and oneshot=0, done SHALL pulse on every tick.
REQ-014 Natural overflow (cnt=2^CNT_W-1 with tick=1, not terminal) SHALL wrap cnt to 0 without a done pulse.
REQ-015 If term changes mid-run to a value below cnt, counting SHALL continue through the wrap until cnt==term.
REQ-016 DONE SHALL last one cycle and then go to IDLE; cnt SHALL hold term until the next start or stop.
REQ-017 start=1 while in DONE SHALL go directly to RUN with cnt=0.
REQ-018 In RUN, pause=1 SHALL go to HOLD next cycle.
REQ-019 In HOLD, cnt and the prescaler SHALL freeze and tick SHALL be 0.
REQ-020 In HOLD, pause=0 SHALL return to RUN, and the prescaler SHALL resume from its frozen phase.
REQ-021 busy SHALL equal (state==RUN or state==HOLD).
REQ-022 oe SHALL equal busy AND (cnt != all-ones), combinational from registered state.
REQ-023 done SHALL be registered; tick SHALL be combinational from the prescaler state.

Reset
REQ-024 rst=1 at a rising clk edge SHALL set: state IDLE, cnt=0, prescaler=0, done=0.
REQ-025 As a consequence of REQ-024 and REQ-021..023, after reset busy=0, oe=0 and tick=0.
REQ-026 rst SHALL override stop, start and pause, including in the middle of a run.

Configuration
REQ-027 With BLINK_CTRL_PRESCALE_EN defined, the prescaler SHALL be present: tick=1 in RUN once every pre_div+1 cycles, with the first tick pre_div+1 cycles after entering RUN.
REQ-028 Without BLINK_CTRL_PRESCALE_EN, no prescaler logic SHALL exist: tick SHALL equal (state==RUN), and pre_div SHALL be ignored.

Structure
REQ-029 Package blink_ctrl_pkg SHALL hold the state enum type (IDLE/RUN/HOLD/DONE) and the default CNT_W and PRE_W constants.
REQ-030 The prescaler SHALL be sub-module blink_prescaler, with ports clk, rst, clr, en, div and tick, instantiated only under BLINK_CTRL_PRESCALE_EN.
REQ-031 The FSM and the count register SHALL live in blink_ctrl.

Verification
REQ-032 rst=1 for 2 cycles, then idle -> cnt=0, busy=0, oe=0, done=0, tick=0.
REQ-033 oneshot=1, term=5, pre_div=0, pulse start -> cnt 0..5 on consecutive cycles; done high for exactly one cycle at cnt=5; state DONE then IDLE; cnt holds 5.
REQ-034 oneshot=0, term=3, pre_div=2 (macro on) -> tick every 3rd cycle; cnt sequence 0,1,2,3,0,...; done pulses every 12 cycles.
REQ-035 Run to cnt=2, pause=1 for 10 cycles, then release -> cnt stays 2 and tick=0 during HOLD; counting resumes at 3 with the prescaler phase preserved.
REQ-036 Run with term=255 -> oe drops when cnt=255. Separately, assert start and stop in the same cycle -> IDLE and cnt=0.
REQ-037 Macro off, pre_div=7 -> tick=1 on every RUN cycle and pre_div has no effect. Separately, assert rst mid-run at cnt=4 -> cnt=0 and IDLE next cycle.
